// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite-ROM read port among NREQ requesters: round-robin grant, or fixed priority with SPRITE_ARB_FIXED_PRI_EN.
// gnt is combinational; rom_rd/rom_addr follow one cycle later, rsp_valid/rsp_data 2+ROM_LAT cycles after gnt; no back-pressure.
module sprite_rom_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic                   rom_rd,
    input  logic [DATA_W-1:0]      rom_data,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ADDR_W-1:0] sel_addr;
    logic              found;
    logic [NREQ-1:0]   tag_pipe [ROM_LAT+1];

`ifndef SPRITE_ARB_FIXED_PRI_EN
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
`endif

    // Search starts at ptr (or at 0 in the fixed-priority build); first requester found wins.
    always_comb begin : grant_search
        int j;
        j        = 0;
        gnt      = '0;
        sel_addr = '0;
        found    = 1'b0;
`ifndef SPRITE_ARB_FIXED_PRI_EN
        win      = '0;
`endif
        if (!Reset) begin
            for (int i = 0; i < NREQ; i++) begin
`ifdef SPRITE_ARB_FIXED_PRI_EN
                j = i;
`else
                j = int'(ptr) + i;
                if (j >= NREQ) begin
                    j = j - NREQ;
                end
`endif
                if (!found && req[j]) begin
                    found    = 1'b1;
                    gnt[j]   = 1'b1;
                    sel_addr = addr[j*ADDR_W +: ADDR_W];
`ifndef SPRITE_ARB_FIXED_PRI_EN
                    win      = PTR_W'(j);
`endif
                end
            end
        end
    end

`ifndef SPRITE_ARB_FIXED_PRI_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_rd   <= 1'b0;
            rom_addr <= '0;
        end else begin
            rom_rd <= found;
            if (found) begin
                rom_addr <= sel_addr;
            end
        end
    end

    // Stage ROM_LAT lines up with the cycle rom_data is valid for the matching read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= gnt;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_pipe[ROM_LAT];
            if (|tag_pipe[ROM_LAT]) begin
                rsp_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM_LAT 1 and 4) share stimulus; a cycle-level
// model predicts every output and directed literal checks pin the model.
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [35:0] addr;

    logic [2:0]  gnt_o      [2];
    logic [11:0] rom_addr_o [2];
    logic        rom_rd_o   [2];
    logic [23:0] rom_data_i [2];
    logic [2:0]  rsp_v_o    [2];
    logic [23:0] rsp_d_o    [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] rom_word(input logic [11:0] a);
        return {~a, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 0) ? 1 : 4;
        logic [23:0] pipe [L];

        sprite_rom_arbiter #(.NREQ(3), .ADDR_W(12), .DATA_W(24), .ROM_LAT(L)) dut (
            .Clk       (clk),
            .Reset     (rst),
            .req       (req),
            .addr      (addr),
            .gnt       (gnt_o[g]),
            .rom_addr  (rom_addr_o[g]),
            .rom_rd    (rom_rd_o[g]),
            .rom_data  (rom_data_i[g]),
            .rsp_valid (rsp_v_o[g]),
            .rsp_data  (rsp_d_o[g])
        );

        // ROM returns zero for cycles without a read so mistimed sampling is visible.
        always @(posedge clk) begin
            pipe[0] <= rom_rd_o[g] ? rom_word(rom_addr_o[g]) : 24'h0;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign rom_data_i[g] = pipe[L-1];
    end

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", nm, g, cyc, act, exp);
        end
    endtask

    // Model: pointer as an integer, future outputs scheduled in a ring indexed by cycle.
    int          ptr_m   [2];
    bit          known   [2];
    bit          e_rd    [2][16];
    logic [2:0]  e_v     [2][16];
    logic [23:0] e_d     [2][16];
    logic [11:0] e_addr  [2];
    logic [23:0] e_last  [2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            known[g] = 0; ptr_m[g] = 0; e_addr[g] = 0; e_last[g] = 0;
            for (int s = 0; s < 16; s++) begin e_rd[g][s] = 0; e_v[g][s] = 0; e_d[g][s] = 0; end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int s, L, k;
            logic [2:0] eg;
            s = cyc % 16;
            L = (g == 0) ? 1 : 4;
            if (known[g]) begin
                check("rom_rd", g, 32'(rom_rd_o[g]), 32'(e_rd[g][s]));
                check("rom_addr", g, 32'(rom_addr_o[g]), 32'(e_addr[g]));
                check("rsp_valid", g, 32'(rsp_v_o[g]), 32'(e_v[g][s]));
                if (e_v[g][s] != 3'b000) e_last[g] = e_d[g][s];
                check("rsp_data", g, 32'(rsp_d_o[g]), 32'(e_last[g]));
                e_rd[g][s] = 0;
                e_v[g][s]  = 3'b000;
            end
            k = -1;
            if (!rst)
                for (int i = 0; i < 3; i++)
                    if (k < 0 && req[(ptr_m[g] + i) % 3]) k = (ptr_m[g] + i) % 3;
            eg = (k >= 0) ? 3'(1 << k) : 3'b000;
            if (rst || known[g]) check("gnt", g, 32'(gnt_o[g]), 32'(eg));
            if (rst) begin
                for (int t = 0; t < 16; t++) begin e_rd[g][t] = 0; e_v[g][t] = 3'b000; end
                ptr_m[g] = 0; e_addr[g] = 0; e_last[g] = 0; known[g] = 1;
            end else if (known[g] && k >= 0) begin
                e_rd[g][(cyc + 1) % 16]     = 1;
                e_addr[g]                   = addr[k*12 +: 12];
                e_v[g][(cyc + 2 + L) % 16]  = eg;
                e_d[g][(cyc + 2 + L) % 16]  = rom_word(addr[k*12 +: 12]);
`ifndef SPRITE_ARB_FIXED_PRI_EN
                ptr_m[g] = (k + 1) % 3;
`endif
            end
        end
    end

    task automatic drive(input logic r, input logic [2:0] q, input logic [11:0] a0, a1, a2);
        @(posedge clk);
        #1;
        rst  = r;
        req  = q;
        addr = {a2, a1, a0};
    endtask

`ifdef SPRITE_ARB_FIXED_PRI_EN
    logic [2:0] rr_exp [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif

    initial begin
        logic [11:0] a [3];
        rst = 1'b1; req = 3'b000; addr = '0;

        // Reset with random requests: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
            @(negedge clk);
            check("rst_gnt", 0, 32'(gnt_o[0]), 32'h0);
            check("rst_rom_rd", 0, 32'(rom_rd_o[0]), 32'h0);
            check("rst_rsp_valid", 0, 32'(rsp_v_o[0]), 32'h0);
            check("rst_rsp_data", 0, 32'(rsp_d_o[0]), 32'h0);
        end
        drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);
        drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);

        // Single requester latency.
        drive(1'b0, 3'b010, 12'h0, 12'h0A5, 12'h0);
        @(negedge clk); check("single_gnt", 0, 32'(gnt_o[0]), 32'h2);
        drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);
        @(negedge clk);
        check("single_rom_rd", 0, 32'(rom_rd_o[0]), 32'h1);
        check("single_rom_addr", 0, 32'(rom_addr_o[0]), 32'h0A5);
        drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);
        drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);
        @(negedge clk);
        check("single_rsp_valid", 0, 32'(rsp_v_o[0]), 32'h2);
        check("single_rsp_data", 0, 32'(rsp_d_o[0]), 32'hF5A0A5);
        for (int i = 0; i < 4; i++) drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);

        // Round-robin from reset, then pointer skip.
        drive(1'b1, 3'b111, 12'h111, 12'h222, 12'h333);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'b111, 12'h111, 12'h222, 12'h333);
            @(negedge clk); check("rr_gnt", 0, 32'(gnt_o[0]), 32'(rr_exp[i]));
        end
        drive(1'b0, 3'b110, 12'h111, 12'h222, 12'h333);
        @(negedge clk); check("skip_gnt", 0, 32'(gnt_o[0]), 32'h2);
        for (int i = 0; i < 8; i++) drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);

        // Reset while two reads are in flight.
        drive(1'b0, 3'b001, 12'h040, 12'h0, 12'h0);
        drive(1'b0, 3'b010, 12'h040, 12'h050, 12'h0);
        drive(1'b1, 3'b111, 12'h040, 12'h050, 12'h060);
        @(negedge clk);
        check("midrst_gnt", 0, 32'(gnt_o[0]), 32'h0);
        check("midrst_rsp", 0, 32'(rsp_v_o[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);
            @(negedge clk);
            check("midrst_rsp", 0, 32'(rsp_v_o[0]), 32'h0);
            check("midrst_rsp", 1, 32'(rsp_v_o[1]), 32'h0);
        end
        drive(1'b0, 3'b111, 12'h070, 12'h080, 12'h090);
        @(negedge clk); check("postrst_gnt", 0, 32'(gnt_o[0]), 32'h1);
        for (int i = 0; i < 8; i++) drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);

        // Eight back-to-back grants; the ROM_LAT=4 instance answers 6 cycles later.
        for (int i = 0; i < 8; i++) begin
            a[0] = 12'h0; a[1] = 12'h0; a[2] = 12'h0;
            a[i % 3] = 12'(12'h100 + i * 12'h023);
            drive(1'b0, 3'(1 << (i % 3)), a[0], a[1], a[2]);
            @(negedge clk);
            if (i == 6) begin
                check("b2b_rsp_valid", 1, 32'(rsp_v_o[1]), 32'h1);
                check("b2b_rsp_data", 1, 32'(rsp_d_o[1]), 32'hEFF100);
            end
            if (i == 7) begin
                check("b2b_rsp_valid", 1, 32'(rsp_v_o[1]), 32'h2);
                check("b2b_rsp_data", 1, 32'(rsp_d_o[1]), 32'hEDC123);
            end
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);

        // Contention with held addresses.
        drive(1'b0, 3'b011, 12'h7A1, 12'h7B2, 12'h7C3);
        drive(1'b0, 3'b011, 12'h7A1, 12'h7B2, 12'h7C3);
        drive(1'b0, 3'b101, 12'h7A1, 12'h7B2, 12'h7C3);
        drive(1'b0, 3'b101, 12'h7A1, 12'h7B2, 12'h7C3);
        for (int i = 0; i < 3; i++) drive(1'b0, 3'b111, 12'h7A1, 12'h7B2, 12'h7C3);
        for (int i = 0; i < 10; i++) drive(1'b0, 3'b000, 12'h0, 12'h0, 12'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite-ROM read port among NREQ pixel-pipeline requesters (character, enemy, platform tile) so that all sprite art can live in a single on-chip memory. It sits between the per-object address generators and the ROM. It grants one read per cycle, tags each read in flight, and returns the ROM data to the requester that issued it.

## Interface
- NREQ, 3: number of requesters; index 0 is the character, 1 the enemy, 2 the tile.
- ADDR_W, 12: ROM address width.
- DATA_W, 24: ROM word width ({R,G,B}, 8 bits each).
- ROM_LAT, 1: ROM read latency in cycles, from rom_rd to valid rom_data; legal range 1–4.

Ports:
- Clk  input  1  system clock; all logic is on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester read request.
- addr  input  NREQ*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  output  NREQ  one-hot grant, combinational, same cycle as req.
- rom_addr  output  ADDR_W  registered address to the ROM.
- rom_rd  output  1  registered read strobe to the ROM.
- rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd.
- rsp_valid  output  NREQ  one-hot response strobe; bit i means rsp_data belongs to requester i.
- rsp_data  output  DATA_W  registered read data.

## Operation
- **Grant.** gnt is a subset of req with at most one bit set. gnt = 0 when req = 0 or Reset = 1.
- **Round-robin.** A pointer ptr (0..NREQ-1) gives the first index searched. The search order is ptr, ptr+1, … modulo NREQ. The first requesting index wins.
- **Pointer update.** On a cycle with a grant to index k, ptr ← (k+1) mod NREQ. With no grant, ptr holds.
- **Request hold.** A requester holds req and addr stable until it sees gnt. It may drop req on the cycle after gnt or issue a new request. If req drops before grant, the request is withdrawn with no side effect.
- **Issue.** On a granted cycle, rom_addr ← addr of the winner and rom_rd ← 1 in the next cycle. Otherwise rom_rd ← 0 and rom_addr holds its last value.
- **Tag pipeline.** A shift register of depth ROM_LAT+1 carries the one-hot grant vector alongside each read. When the tag leaves the pipeline: rsp_valid ← tag and rsp_data ← rom_data sampled at the matching cycle.
- **Hold values.** rsp_data holds its last value when rsp_valid = 0. rsp_valid is 0 on cycles with no completing read.
- **Throughput.** One grant per cycle, sustained indefinitely. No back-pressure; requesters always accept rsp_valid.

## Timing
- Grant in cycle t gives rom_rd = 1 and rom_addr in cycle t+1.
- rom_data is valid in cycle t+1+ROM_LAT.
- rsp_valid and rsp_data are valid in cycle t+2+ROM_LAT, which is 3 cycles for ROM_LAT = 1.
- Responses return in grant order. Several reads in flight (up to ROM_LAT+1) are legal.
- Reset values: gnt = 0, rom_rd = 0, rom_addr = 0, rsp_valid = 0, rsp_data = 0, ptr = 0, tag pipeline all zero.
- **Reset mid-operation.** All in-flight tags are cleared. No rsp_valid is asserted for reads issued before Reset, even if rom_data arrives later.
- **Simultaneous events.** If req is asserted in the same cycle as Reset, no grant is given and ptr stays 0.
- **Requester re-request.** A requester that re-requests in the cycle after its grant competes normally. Its index is now last in round-robin order.

## Configuration
- Macro: SPRITE_ARB_FIXED_PRI_EN.
- **Defined:** fixed priority, lowest index wins (the character always beats enemy and tile). ptr is not implemented; its reset and update rules do not apply.
- **Undefined:** round-robin as described above.
- Latency, tagging and reset behaviour are identical in both builds.

## Test plan
- **Reset values.** Assert Reset with random req/addr -> gnt = 0, rom_rd = 0, rsp_valid = 0, rsp_data = 0 every cycle of reset.
- **Single requester latency.** req = 3'b010, addr[1] = 12'h0A5 in cycle 5, ROM_LAT = 1 -> gnt = 3'b010 in cycle 5; rom_rd = 1 and rom_addr = 12'h0A5 in cycle 6; rsp_valid = 3'b010 with the ROM word at 0x0A5 in cycle 8.
- **Round-robin fairness.** req = 3'b111 held for 6 cycles from reset -> gnt sequence 001, 010, 100, 001, 010, 100. The responses follow the same sequence 3 cycles later. Under SPRITE_ARB_FIXED_PRI_EN the gnt is 001 every cycle.
- **Pointer skip.** After a grant to index 2, req = 3'b110 -> gnt = 3'b010 (ptr = 0, index 0 idle, so index 1 is next).
- **Reset mid-flight.** Grants in cycles 10 and 11, Reset high in cycle 12 -> no rsp_valid in cycles 12–15; the first grant after Reset goes to index 0.
- **ROM_LAT = 4 back-to-back.** 8 consecutive grants -> 8 rsp_valid pulses on consecutive cycles, each 6 cycles after its grant, with data matching its address.
